doc5503_host_port: RTL and testbench

Host-side register access controller for the DOC 5503 sound core. It sits directly upstream of the seven per-group register RAMs. It turns CPU bus transactions on the 256-byte DOC register map into one-cycle edge-triggered priority write/read request pulses, waits a fixed service window, and returns read data to the host. It also implements the group-7 special registers locally: interrupt status, oscillator enable and A/D.

---
 rtl/doc5503_host_port_if.sv | 20 ++
 rtl/doc5503_host_port.sv | 204 ++++++++++++++++++++
 tb/tb_doc5503_host_port.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/doc5503_host_port_if.sv
// Host CPU bus of the DOC 5503 register port: a level strobe held until a
// one-cycle ack, with read data returned alongside the ack.
interface doc5503_host_port_if;
  logic       host_sel_i;
  logic       host_we_i;
  logic [7:0] host_addr_i;
  logic [7:0] host_data_i;
  logic [7:0] host_data_o;
  logic       host_ack_o;

  modport master (
    output host_sel_i, host_we_i, host_addr_i, host_data_i,
    input  host_data_o, host_ack_o
  );

  modport slave (
    input  host_sel_i, host_we_i, host_addr_i, host_data_i,
    output host_data_o, host_ack_o
  );
endinterface

// File: rtl/doc5503_host_port.sv
// DOC 5503 host register port: turns CPU accesses into per-group RAM request
// pulses and serves group 7 locally. DOC5503_HOST_IRQ_EN enables the IRQ pending register.
//
// state    | meaning
// ST_IDLE  | waiting for an armed host strobe
// ST_WRITE | write request issued, counting the write service window
// ST_READ  | read request issued, counting the read window, then capture
// ST_DONE  | raise host_ack_o for one cycle, back to idle
module doc5503_host_port #(
  parameter int unsigned WRITE_WAIT = 2,
  parameter int unsigned READ_WAIT  = 3
) (
  input  logic            clk_i,
  input  logic            reset_i,
  doc5503_host_port_if.slave host,
  output logic [6:0]      ram_wr_req_o,
  output logic [6:0]      ram_rd_req_o,
  output logic [4:0]      ram_addr_o,
  output logic [7:0]      ram_wr_data_o,
  input  logic [6:0][7:0] ram_rd_data_i,
  input  logic            irq_set_i,
  input  logic [4:0]      irq_osc_i,
  output logic            irq_o,
  output logic [4:0]      osc_count_o,
  input  logic [7:0]      adc_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The issue cycle already covers one cycle of the window, hence the -1.
  localparam logic [7:0] WR_LOAD = 8'((WRITE_WAIT > 0) ? WRITE_WAIT - 1 : 0);
  localparam logic [7:0] RD_LOAD = 8'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);

  state_t     state_r;
  logic       armed_r;
  logic       issue_r;
  logic       we_r;
  logic [7:0] addr_r;
  logic [7:0] wdata_r;
  logic [7:0] cnt_r;
  logic [7:0] osc_en_r;

  logic [2:0] grp;
  logic       is_g7;
  logic [6:0] grp_onehot;
  logic [7:0] irq_rd_val;
  logic [7:0] g7_rdata;

  assign grp         = addr_r[7:5];
  assign is_g7       = (grp == 3'd7);
  assign grp_onehot  = 7'd1 << grp;
  assign osc_count_o = osc_en_r[5:1];

  always_comb begin
    g7_rdata = 8'h00;
    case (addr_r[4:0])
      5'd0:    g7_rdata = irq_rd_val;
      5'd1:    g7_rdata = osc_en_r;
      5'd2:    g7_rdata = adc_i;
      default: g7_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r          <= ST_IDLE;
      armed_r          <= 1'b0;
      issue_r          <= 1'b0;
      we_r             <= 1'b0;
      addr_r           <= 8'h00;
      wdata_r          <= 8'h00;
      cnt_r            <= 8'h00;
      osc_en_r         <= 8'h00;
      host.host_data_o <= 8'h00;
      host.host_ack_o  <= 1'b0;
      ram_wr_req_o     <= 7'd0;
      ram_rd_req_o     <= 7'd0;
      ram_addr_o       <= 5'd0;
      ram_wr_data_o    <= 8'h00;
    end else begin
      ram_wr_req_o    <= 7'd0;
      ram_rd_req_o    <= 7'd0;
      host.host_ack_o <= 1'b0;
      issue_r         <= 1'b0;
      // A new access is only accepted after the strobe has been seen low.
      if (!host.host_sel_i) armed_r <= 1'b1;

      case (state_r)
        ST_IDLE: begin
          if (host.host_sel_i && armed_r) begin
            armed_r <= 1'b0;
            addr_r  <= host.host_addr_i;
            wdata_r <= host.host_data_i;
            we_r    <= host.host_we_i;
            issue_r <= 1'b1;
            state_r <= host.host_we_i ? ST_WRITE : ST_READ;
          end
        end

        ST_WRITE: begin
          if (issue_r) begin
            if (is_g7) begin
              if (addr_r[4:0] == 5'd1) osc_en_r <= wdata_r;
              state_r <= ST_DONE;
            end else begin
              // Group 3 is wave data: no pulse, but the same service window.
              ram_wr_req_o  <= (grp == 3'd3) ? 7'd0 : grp_onehot;
              ram_addr_o    <= addr_r[4:0];
              ram_wr_data_o <= wdata_r;
              cnt_r         <= WR_LOAD;
            end
          end else if (cnt_r == 8'd0) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end

        ST_READ: begin
          if (issue_r) begin
            if (is_g7) begin
              host.host_data_o <= g7_rdata;
              state_r          <= ST_DONE;
            end else begin
              ram_rd_req_o <= grp_onehot;
              ram_addr_o   <= addr_r[4:0];
              cnt_r        <= RD_LOAD;
            end
          end else if (cnt_r == 8'd0) begin
            host.host_data_o <= ram_rd_data_i[grp];
            state_r          <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end

        ST_DONE: begin
          host.host_ack_o <= 1'b1;
          state_r         <= ST_IDLE;
        end

        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef DOC5503_HOST_IRQ_EN
  logic [31:0] pending_r;
  logic [31:0] pending_nxt;
  logic        irq_any;
  logic [4:0]  irq_low;
  logic        clr_vld_r;
  logic [4:0]  clr_osc_r;
  logic        e0_rd;

  assign irq_any    = |pending_r;
  assign irq_rd_val = irq_any ? {2'b01, irq_low, 1'b1} : 8'hFF;
  assign e0_rd      = (state_r == ST_READ) && issue_r && (addr_r == 8'hE0);

  always_comb begin
    irq_low = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pending_r[i]) irq_low = 5'(i);
    end
  end

  // The reported oscillator is cleared with the ack; a same-cycle set wins.
  always_comb begin
    pending_nxt = pending_r;
    if ((state_r == ST_DONE) && clr_vld_r) pending_nxt[clr_osc_r] = 1'b0;
    if (irq_set_i) pending_nxt[irq_osc_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_r <= 32'd0;
      clr_vld_r <= 1'b0;
      clr_osc_r <= 5'd0;
      irq_o     <= 1'b0;
    end else begin
      pending_r <= pending_nxt;
      irq_o     <= |pending_nxt;
      if (e0_rd) begin
        clr_vld_r <= irq_any;
        clr_osc_r <= irq_low;
      end else if (state_r == ST_DONE) begin
        clr_vld_r <= 1'b0;
      end
    end
  end
`else
  logic unused_irq;

  assign irq_rd_val = 8'hFF;
  assign irq_o      = 1'b0;
  assign unused_irq = ^{irq_set_i, irq_osc_i};
`endif

endmodule

// File: tb/tb_doc5503_host_port.sv
// Directed bench for doc5503_host_port with default WRITE_WAIT=2, READ_WAIT=3.
// IRQ expectations follow DOC5503_HOST_IRQ_EN as seen by this compilation.
module tb_doc5503_host_port;

`ifdef DOC5503_HOST_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic [6:0]      ram_wr_req_o;
  logic [6:0]      ram_rd_req_o;
  logic [4:0]      ram_addr_o;
  logic [7:0]      ram_wr_data_o;
  logic [6:0][7:0] ram_rd_data_i;
  logic            irq_set_i = 1'b0;
  logic [4:0]      irq_osc_i = 5'd0;
  logic            irq_o;
  logic [4:0]      osc_count_o;
  logic [7:0]      adc_i = 8'h00;

  int checks = 0;
  int errors = 0;

  int         ack_cyc, req_cyc, req_cnt, n_ack;
  logic [6:0] wr_seen, rd_seen;
  logic [4:0] addr_seen;
  logic [7:0] wdat_seen, rdata_seen;
  logic       ack_acc;

  doc5503_host_port_if host_if();

  doc5503_host_port #(.WRITE_WAIT(2), .READ_WAIT(3)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .host          (host_if),
    .ram_wr_req_o  (ram_wr_req_o),
    .ram_rd_req_o  (ram_rd_req_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
    .ram_rd_data_i (ram_rd_data_i),
    .irq_set_i     (irq_set_i),
    .irq_osc_i     (irq_osc_i),
    .irq_o         (irq_o),
    .osc_count_o   (osc_count_o),
    .adc_i         (adc_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Cycle c is the cycle following clock edge c; edge 0 samples the strobe.
  task automatic do_xact(input logic we, input logic [7:0] addr, input logic [7:0] data);
    host_if.host_we_i   = we;
    host_if.host_addr_i = addr;
    host_if.host_data_i = data;
    host_if.host_sel_i  = 1'b1;
    ack_cyc = -1; req_cyc = -1; req_cnt = 0;
    wr_seen = '0; rd_seen = '0; addr_seen = '0; wdat_seen = '0; rdata_seen = '0;
    for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
      tick();
      if ((ram_wr_req_o | ram_rd_req_o) != 7'd0) begin
        req_cnt++;
        if (req_cyc < 0) begin
          req_cyc   = c;
          wr_seen   = ram_wr_req_o;
          rd_seen   = ram_rd_req_o;
          addr_seen = ram_addr_o;
          wdat_seen = ram_wr_data_o;
        end
      end
      if (host_if.host_ack_o) begin
        ack_cyc    = c;
        rdata_seen = host_if.host_data_o;
      end
    end
    host_if.host_sel_i = 1'b0;
    tick();
    check_val("ack_one_cycle", host_if.host_ack_o, 0);
  endtask

  task automatic pulse_irq(input logic [4:0] osc);
    irq_osc_i = osc;
    irq_set_i = 1'b1;
    tick();
    irq_set_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data"},  host_if.host_data_o, 0);
    check_val({tag, "_ack"},   host_if.host_ack_o, 0);
    check_val({tag, "_wrreq"}, ram_wr_req_o, 0);
    check_val({tag, "_rdreq"}, ram_rd_req_o, 0);
    check_val({tag, "_addr"},  ram_addr_o, 0);
    check_val({tag, "_wdata"}, ram_wr_data_o, 0);
    check_val({tag, "_irq"},   irq_o, 0);
    check_val({tag, "_osccnt"}, osc_count_o, 0);
  endtask

  initial begin
    for (int g = 0; g < 7; g++) ram_rd_data_i[g] = 8'h10 + 8'(g);
    ram_rd_data_i[4] = 8'hA5;
    host_if.host_sel_i  = 1'b0;
    host_if.host_we_i   = 1'b0;
    host_if.host_addr_i = 8'h00;
    host_if.host_data_i = 8'h00;

    tick(); tick();
    check_reset_outputs("por");
    reset_i = 1'b0;
    tick();

    // Group writes, including the read-only wave-data group.
    do_xact(1'b1, 8'h25, 8'h7F);
    check_val("w25_wrreq", wr_seen, 7'b0000010);
    check_val("w25_rdreq", rd_seen, 7'b0000000);
    check_val("w25_reqcyc", req_cyc, 1);
    check_val("w25_reqcnt", req_cnt, 1);
    check_val("w25_addr", addr_seen, 5);
    check_val("w25_wdata", wdat_seen, 8'h7F);
    check_val("w25_ack", ack_cyc, 4);

    do_xact(1'b1, 8'h61, 8'h12);
    check_val("w61_reqcnt", req_cnt, 0);
    check_val("w61_ack", ack_cyc, 4);

    do_xact(1'b1, 8'hC7, 8'h99);
    check_val("wC7_wrreq", wr_seen, 7'b1000000);
    check_val("wC7_addr", addr_seen, 7);
    check_val("wC7_wdata", wdat_seen, 8'h99);

    // Group reads.
    do_xact(1'b0, 8'h83, 8'h00);
    check_val("r83_rdreq", rd_seen, 7'b0010000);
    check_val("r83_wrreq", wr_seen, 7'b0000000);
    check_val("r83_reqcyc", req_cyc, 1);
    check_val("r83_reqcnt", req_cnt, 1);
    check_val("r83_addr", addr_seen, 3);
    check_val("r83_ack", ack_cyc, 5);
    check_val("r83_data", rdata_seen, 8'hA5);

    do_xact(1'b0, 8'h40, 8'h00);
    check_val("r40_rdreq", rd_seen, 7'b0000100);
    check_val("r40_ack", ack_cyc, 5);
    check_val("r40_data", rdata_seen, 8'h12);

    do_xact(1'b1, 8'h05, 8'h44);
    check_val("w05_wrreq", wr_seen, 7'b0000001);
    check_val("data_held", host_if.host_data_o, 8'h12);

    // Group 7 local registers.
    do_xact(1'b1, 8'hE1, 8'h3E);
    check_val("wE1_ack", ack_cyc, 2);
    check_val("wE1_reqcnt", req_cnt, 0);
    check_val("osc_count_31", osc_count_o, 31);
    do_xact(1'b0, 8'hE1, 8'h00);
    check_val("rE1_ack", ack_cyc, 2);
    check_val("rE1_reqcnt", req_cnt, 0);
    check_val("rE1_data", rdata_seen, 8'h3E);
    do_xact(1'b1, 8'hE1, 8'h06);
    check_val("osc_count_3", osc_count_o, 3);
    do_xact(1'b1, 8'hE1, 8'h3E);
    do_xact(1'b1, 8'hE2, 8'h55);
    do_xact(1'b1, 8'hE0, 8'h00);
    do_xact(1'b0, 8'hE1, 8'h00);
    check_val("rE1_after_ignored", rdata_seen, 8'h3E);

    adc_i = 8'h80;
    do_xact(1'b0, 8'hE2, 8'h00);
    check_val("rE2_ack", ack_cyc, 2);
    check_val("rE2_data80", rdata_seen, 8'h80);
    adc_i = 8'h3C;
    do_xact(1'b0, 8'hE2, 8'h00);
    check_val("rE2_data3C", rdata_seen, 8'h3C);
    do_xact(1'b0, 8'hE5, 8'h00);
    check_val("rE5_data", rdata_seen, 8'h00);
    do_xact(1'b0, 8'hFF, 8'h00);
    check_val("rFF_data", rdata_seen, 8'h00);

    // Interrupt register.
    check_val("irq_idle", irq_o, 0);
    pulse_irq(5'd9);
    check_val("irq_rise", irq_o, IRQ_EN);
    pulse_irq(5'd3);
    do_xact(1'b0, 8'hE0, 8'h00);
    check_val("rE0_first", rdata_seen, IRQ_EN ? 8'h47 : 8'hFF);
    check_val("irq_after_first", irq_o, IRQ_EN);
    do_xact(1'b0, 8'hE0, 8'h00);
    check_val("rE0_second", rdata_seen, IRQ_EN ? 8'h53 : 8'hFF);
    check_val("irq_after_second", irq_o, 0);
    do_xact(1'b0, 8'hE0, 8'h00);
    check_val("rE0_empty", rdata_seen, 8'hFF);

    // Set of osc 3 on the same edge as its clear keeps it pending.
    pulse_irq(5'd3);
    host_if.host_we_i   = 1'b0;
    host_if.host_addr_i = 8'hE0;
    host_if.host_sel_i  = 1'b1;
    tick(); tick();
    irq_osc_i = 5'd3;
    irq_set_i = 1'b1;
    tick();
    irq_set_i = 1'b0;
    check_val("setclr_ack", host_if.host_ack_o, 1);
    check_val("setclr_data", host_if.host_data_o, IRQ_EN ? 8'h47 : 8'hFF);
    host_if.host_sel_i = 1'b0;
    tick();
    check_val("setclr_irq", irq_o, IRQ_EN);
    do_xact(1'b0, 8'hE0, 8'h00);
    check_val("setclr_reread", rdata_seen, IRQ_EN ? 8'h47 : 8'hFF);
    check_val("setclr_irq_end", irq_o, 0);

    // Held strobe does not retrigger; a one-cycle drop re-arms.
    host_if.host_we_i   = 1'b0;
    host_if.host_addr_i = 8'h20;
    host_if.host_sel_i  = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (host_if.host_ack_o) begin
        n_ack++;
        rdata_seen = host_if.host_data_o;
      end
    end
    check_val("held_acks", n_ack, 1);
    check_val("held_data", rdata_seen, 8'h11);
    host_if.host_sel_i = 1'b0;
    tick();
    host_if.host_sel_i = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (host_if.host_ack_o) n_ack++;
    end
    check_val("rearm_acks", n_ack, 1);
    host_if.host_sel_i = 1'b0;
    tick();

    // Dropping the strobe mid-transaction does not abort it.
    host_if.host_we_i   = 1'b1;
    host_if.host_addr_i = 8'h05;
    host_if.host_data_i = 8'h44;
    host_if.host_sel_i  = 1'b1;
    tick();
    host_if.host_sel_i = 1'b0;
    req_cyc = -1; ack_cyc = -1; wr_seen = '0;
    for (int c = 1; c < 12; c++) begin
      tick();
      if (ram_wr_req_o != 7'd0 && req_cyc < 0) begin
        req_cyc = c;
        wr_seen = ram_wr_req_o;
      end
      if (host_if.host_ack_o && ack_cyc < 0) ack_cyc = c;
    end
    check_val("drop_wrreq", wr_seen, 7'b0000001);
    check_val("drop_reqcyc", req_cyc, 1);
    check_val("drop_ack", ack_cyc, 4);

    // Reset during a read at cycle 3.
    host_if.host_we_i   = 1'b0;
    host_if.host_addr_i = 8'h83;
    host_if.host_sel_i  = 1'b1;
    tick(); tick(); tick(); tick();
    reset_i = 1'b1;
    #1;
    check_reset_outputs("rst_rd");
    host_if.host_sel_i = 1'b0;
    tick();
    reset_i = 1'b0;
    ack_acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ack_acc = ack_acc | host_if.host_ack_o;
    end
    check_val("rst_rd_noack", ack_acc, 0);
    do_xact(1'b0, 8'h83, 8'h00);
    check_val("post_rst_ack", ack_cyc, 5);
    check_val("post_rst_data", rdata_seen, 8'hA5);

    // Reset while a write pulse is on the bus clears it immediately.
    host_if.host_we_i   = 1'b1;
    host_if.host_addr_i = 8'h25;
    host_if.host_data_i = 8'h7F;
    host_if.host_sel_i  = 1'b1;
    tick(); tick();
    check_val("rst_wr_pre", ram_wr_req_o, 7'b0000010);
    reset_i = 1'b1;
    #1;
    check_val("rst_wr_req", ram_wr_req_o, 0);
    check_val("rst_wr_wdata", ram_wr_data_o, 0);
    host_if.host_sel_i = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();
    do_xact(1'b1, 8'h25, 8'h7F);
    check_val("post_rst_w_ack", ack_cyc, 4);
    check_val("post_rst_w_req", wr_seen, 7'b0000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
